// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a 2-entry skid buffer, so a MEM stall never reaches EX combinationally.
// Adds a hazard flush, bubble squashing of side-effecting controls and a saturating stall counter.
module ex_mem_skid_reg #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int RSRC_W = 2,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              ValidE,
   output logic              ReadyE,
   input  logic [XLEN-1:0]   ALUResult,
   input  logic [XLEN-1:0]   WriteDataE,
   input  logic [XLEN-1:0]   PCPlus4E,
   input  logic [REG_AW-1:0] RdE,
   input  logic              RegWriteE,
   input  logic              MemWriteE,
   input  logic [RSRC_W-1:0] ResultSrcE,
   input  logic              ReadyM,
   output logic              ValidM,
   output logic [XLEN-1:0]   ALUResultM,
   output logic [XLEN-1:0]   WriteDataM,
   output logic [XLEN-1:0]   PCPlus4M,
   output logic [REG_AW-1:0] RdM,
   output logic              RegWriteM,
   output logic              MemWriteM,
   output logic [RSRC_W-1:0] ResultSrcM,
   output logic [CNT_W-1:0]  StallCnt,
   output logic [1:0]        state_dbg_o
);

   localparam int PW = 3*XLEN + REG_AW + 2 + RSRC_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     main_q, main_d;
   logic [PW-1:0]     skid_q, skid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ready_q, ready_d;
   logic [PW-1:0]     in_pl;
   logic              valid_m;
   logic              accept;
   logic              drain;

   logic [XLEN-1:0]   alu_h, wd_h, pc_h;
   logic [REG_AW-1:0] rd_h;
   logic              rw_h, mw_h;
   logic [RSRC_W-1:0] rs_h;

   assign in_pl   = {ALUResult, WriteDataE, PCPlus4E, RdE, RegWriteE, MemWriteE, ResultSrcE};
   assign valid_m = (state_q != EMPTY);
   assign accept  = ValidE & ready_q;
   assign drain   = valid_m & ReadyM;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      cnt_d   = cnt_q;

      if (flush) begin
         // Flush wins over any same-cycle accept or drain; the counter keeps its value.
         state_d = EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end else begin
         if (valid_m && !ReadyM && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);

         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  main_d  = in_pl;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  main_d = in_pl;
               end else if (accept) begin
                  state_d = FULL;
                  skid_d  = in_pl;
               end else if (drain) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (drain) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end

      // ReadyE is registered: it only reflects whether the skid slot will be free.
      ready_d = (state_d != FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   assign {alu_h, wd_h, pc_h, rd_h, rw_h, mw_h, rs_h} = main_q;

   assign ReadyE      = ready_q;
   assign ValidM      = valid_m;
   assign ALUResultM  = alu_h;
   assign WriteDataM  = wd_h;
   assign PCPlus4M    = pc_h;
   assign ResultSrcM  = rs_h;
   // Bubbles must never write the register file or memory, whatever stale data sits in main.
   assign RdM         = valid_m ? rd_h : '0;
   assign RegWriteM   = valid_m & rw_h;
   assign MemWriteM   = valid_m & mw_h;
   assign StallCnt    = cnt_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Directed bench for ex_mem_skid_reg: accepted entries go into an expected queue,
// a negedge monitor pops and compares every drained head; directed checks cover the rest.
module tb_ex_mem_skid_reg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;
   localparam int RSRC_W = 2;
   localparam int CNT_W  = 4;
   localparam int W      = 3*XLEN + REG_AW + 2 + RSRC_W;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              ValidE;
   logic              ReadyE;
   logic [XLEN-1:0]   ALUResult;
   logic [XLEN-1:0]   WriteDataE;
   logic [XLEN-1:0]   PCPlus4E;
   logic [REG_AW-1:0] RdE;
   logic              RegWriteE;
   logic              MemWriteE;
   logic [RSRC_W-1:0] ResultSrcE;
   logic              ReadyM;
   logic              ValidM;
   logic [XLEN-1:0]   ALUResultM;
   logic [XLEN-1:0]   WriteDataM;
   logic [XLEN-1:0]   PCPlus4M;
   logic [REG_AW-1:0] RdM;
   logic              RegWriteM;
   logic              MemWriteM;
   logic [RSRC_W-1:0] ResultSrcM;
   logic [CNT_W-1:0]  StallCnt;
   logic [1:0]        state_dbg_o;

   logic [W-1:0] exp_q[$];
   int n_total;
   int n_pass;

   ex_mem_skid_reg #(
      .XLEN(XLEN), .REG_AW(REG_AW), .RSRC_W(RSRC_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .ValidE(ValidE), .ReadyE(ReadyE),
      .ALUResult(ALUResult), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
      .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
      .ReadyM(ReadyM), .ValidM(ValidM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
      .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .StallCnt(StallCnt), .state_dbg_o(state_dbg_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Scoreboard monitor: every handshaken head (outside rst/flush) must match the queue front.
   always @(negedge clk) begin
      if (!rst && !flush && ValidM && ReadyM) begin
         logic [W-1:0] act;
         logic [W-1:0] exp;
         act = {ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM};
         n_total++;
         if (exp_q.size() == 0) begin
            $display("FAIL drain_unexpected: got 0x%0h expected no entry", act);
         end else begin
            exp = exp_q.pop_front();
            if (act === exp) n_pass++;
            else $display("FAIL drain_payload: got 0x%0h expected 0x%0h", act, exp);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                        input logic rw, input logic mw, input logic rdy_m, input logic push);
      ValidE     = v;
      ALUResult  = alu;
      WriteDataE = alu ^ 32'h5A5A_0000;
      PCPlus4E   = alu + 32'd4;
      RdE        = rd;
      RegWriteE  = rw;
      MemWriteE  = mw;
      ResultSrcE = alu[5:4];
      ReadyM     = rdy_m;
      if (push)
         exp_q.push_back({alu, alu ^ 32'h5A5A_0000, alu + 32'd4, rd, rw, mw, alu[5:4]});
      tick();
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst = 1'b1;
      flush = 1'b0;
      ValidE = 1'b1;
      ALUResult = 32'hDEAD_BEEF;
      WriteDataE = 32'h1111_2222;
      PCPlus4E = 32'h3333_4444;
      RdE = 5'd9;
      RegWriteE = 1'b1;
      MemWriteE = 1'b1;
      ResultSrcE = 2'd3;
      ReadyM = 1'b0;

      // Reset held two cycles with live input
      tick();
      tick();
      chk("rst_validm", 32'(ValidM), 0);
      chk("rst_alum", ALUResultM, 0);
      chk("rst_wdm", WriteDataM, 0);
      chk("rst_pcm", PCPlus4M, 0);
      chk("rst_rdm", 32'(RdM), 0);
      chk("rst_ctl", {28'd0, RegWriteM, MemWriteM, ResultSrcM}, 0);
      chk("rst_readye", 32'(ReadyE), 1);
      chk("rst_stallcnt", 32'(StallCnt), 0);
      chk("rst_state", 32'(state_dbg_o), 0);
      rst = 1'b0;
      ValidE = 1'b0;

      // Streaming: each entry visible one cycle after its accept edge
      drive(1, 32'h10, 5'd1, 1, 0, 1, 1);
      chk("stream0_alu", ALUResultM, 32'h10);
      chk("stream0_rd", 32'(RdM), 1);
      chk("stream0_ready", 32'(ReadyE), 1);
      drive(1, 32'h20, 5'd2, 1, 0, 1, 1);
      chk("stream1_alu", ALUResultM, 32'h20);
      chk("stream1_rd", 32'(RdM), 2);
      chk("stream1_ready", 32'(ReadyE), 1);
      drive(1, 32'h30, 5'd3, 1, 0, 1, 1);
      chk("stream2_alu", ALUResultM, 32'h30);
      chk("stream2_rd", 32'(RdM), 3);
      chk("stream2_ready", 32'(ReadyE), 1);
      drive(0, 32'h0, 5'd0, 0, 0, 1, 0);
      chk("stream_empty", 32'(ValidM), 0);
      chk("stream_nostall", 32'(StallCnt), 0);

      // Stall / skid
      drive(1, 32'h100, 5'd4, 1, 0, 0, 1);
      chk("skidA_state", 32'(state_dbg_o), 1);
      drive(1, 32'h200, 5'd5, 1, 1, 0, 1);
      chk("skid_full_state", 32'(state_dbg_o), 2);
      chk("skid_full_ready", 32'(ReadyE), 0);
      chk("skid_full_alu", ALUResultM, 32'h100);
      chk("skid_full_cnt", 32'(StallCnt), 1);
      for (int i = 0; i < 4; i++) drive(0, 32'h0, 5'd0, 0, 0, 0, 0);
      chk("stall_cnt", 32'(StallCnt), 5);
      chk("stall_alu", ALUResultM, 32'h100);
      chk("stall_rd", 32'(RdM), 4);
      chk("stall_ready", 32'(ReadyE), 0);
      drive(0, 32'h0, 5'd0, 0, 0, 1, 0);
      chk("release_alu", ALUResultM, 32'h200);
      chk("release_ready", 32'(ReadyE), 1);
      chk("release_cnt", 32'(StallCnt), 5);
      drive(0, 32'h0, 5'd0, 0, 0, 1, 0);
      chk("release_empty", 32'(ValidM), 0);

      // Bubble squash: stale main holds RegWrite/MemWrite/Rd=5 from the last entry
      drive(0, 32'h777, 5'd7, 1, 1, 1, 0);
      drive(0, 32'h777, 5'd7, 1, 1, 1, 0);
      chk("bubble_validm", 32'(ValidM), 0);
      chk("bubble_regwrite", 32'(RegWriteM), 0);
      chk("bubble_memwrite", 32'(MemWriteM), 0);
      chk("bubble_rd", 32'(RdM), 0);

      // Flush while FULL, with a valid store presented and MEM stalled
      drive(1, 32'h300, 5'd6, 1, 0, 0, 1);
      drive(1, 32'h400, 5'd8, 1, 1, 0, 1);
      chk("pre_flush_state", 32'(state_dbg_o), 2);
      chk("pre_flush_cnt", 32'(StallCnt), 6);
      exp_q.delete();
      flush = 1'b1;
      drive(1, 32'h999, 5'd10, 1, 1, 0, 0);
      flush = 1'b0;
      chk("flush_validm", 32'(ValidM), 0);
      chk("flush_memwrite", 32'(MemWriteM), 0);
      chk("flush_regwrite", 32'(RegWriteM), 0);
      chk("flush_rd", 32'(RdM), 0);
      chk("flush_alu", ALUResultM, 0);
      chk("flush_ready", 32'(ReadyE), 1);
      chk("flush_cnt_kept", 32'(StallCnt), 6);
      drive(0, 32'h0, 5'd0, 0, 0, 1, 0);
      drive(0, 32'h0, 5'd0, 0, 0, 1, 0);
      chk("post_flush_validm", 32'(ValidM), 0);

      // Saturation of the 4-bit counter
      drive(1, 32'h500, 5'd11, 1, 0, 0, 1);
      for (int i = 0; i < 20; i++) drive(0, 32'h0, 5'd0, 0, 0, 0, 0);
      chk("sat_cnt", 32'(StallCnt), 15);
      drive(0, 32'h0, 5'd0, 0, 0, 0, 0);
      drive(0, 32'h0, 5'd0, 0, 0, 0, 0);
      chk("sat_hold", 32'(StallCnt), 15);
      chk("sat_validm", 32'(ValidM), 1);
      chk("sat_alu", ALUResultM, 32'h500);
      rst = 1'b1;
      exp_q.delete();
      drive(0, 32'h0, 5'd0, 0, 0, 0, 0);
      rst = 1'b0;
      chk("sat_rst_cnt", 32'(StallCnt), 0);
      chk("sat_rst_validm", 32'(ValidM), 0);
      chk("sat_rst_ready", 32'(ReadyE), 1);

      // Every accepted, unflushed entry must have drained
      chk("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- Parametrised successor to the fixed EX/MEM pipeline register.
- Carries the EX-stage result bundle into MEM through a 2-entry skid buffer with valid/ready handshake, so a MEM-side stall (e.g. a multi-cycle data memory) does not combinationally back-propagate into EX.
- Adds a hazard-unit flush, bubble squashing of side-effecting control bits, and a saturating stall-cycle counter for performance monitoring.

Parameters:
- XLEN, 32, width of ALUResult/WriteData/PCPlus4 fields.
- REG_AW, 5, width of destination register index.
- RSRC_W, 2, width of ResultSrc select.
- CNT_W, 16, width of stall-cycle counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- ValidE  in  1  EX presents a valid instruction.
- ReadyE  out  1  buffer can accept this cycle (registered).
- ALUResult  in  XLEN  EX ALU result.
- WriteDataE  in  XLEN  store data.
- PCPlus4E  in  XLEN  PC+4 of the instruction.
- RdE  in  REG_AW  destination register.
- RegWriteE  in  1  register-write enable.
- MemWriteE  in  1  memory-write enable.
- ResultSrcE  in  RSRC_W  writeback mux select.
- ReadyM  in  1  MEM consumes the head entry this cycle.
- ValidM  out  1  head entry valid.
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN  head payload.
- RdM  out  REG_AW  head destination, forced 0 when ValidM=0.
- RegWriteM, MemWriteM  out  1  gated by ValidM.
- ResultSrcM  out  RSRC_W  head select.
- StallCnt  out  CNT_W  saturating count of cycles with ValidM=1 and ReadyM=0.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Storage:
  - main entry, which drives the M outputs;
  - skid entry, with its own valid bit;
  - occupancy state EMPTY (no valid), ONE (main valid), FULL (main+skid valid).
- Handshakes:
  - ReadyE = NOT skid_valid, driven from a register with no combinational path from ReadyM.
  - Accept = ValidE & ReadyE.
  - Drain = ValidM & ReadyM.
- Transitions (no rst/flush):
  - EMPTY: accept -> ONE, load main.
  - ONE, accept & drain -> ONE, load main with new data.
  - ONE, accept & !drain -> FULL, load skid.
  - ONE, !accept & drain -> EMPTY.
  - ONE, neither -> hold.
  - FULL: accept impossible (ReadyE=0).
  - FULL, drain -> ONE, move skid into main, clear skid_valid.
  - FULL, !drain -> hold all.
- Latency: input accepted at edge N is visible on M outputs after edge N when the buffer was EMPTY or draining; otherwise it sits in skid until the head drains. Ordering is strictly FIFO.
- Throughput: one entry per cycle when ReadyM stays 1.
- Bubble squash: when ValidM=0, RegWriteM=0, MemWriteM=0 and RdM=0, whatever the stored data.
- Reset priority: rst > flush > normal.
  - rst clears both valids, all stored payload to 0, and StallCnt to 0.
  - After rst, all M outputs and ValidM read 0, ReadyE=1, state EMPTY.
  - rst asserted mid-stall (FULL) discards both entries.
- Flush:
  - Clears both valids and payload to 0.
  - Discards any same-cycle input, even if ValidE=1.
  - Discards any drain handshake in that cycle: the head is not counted as consumed by this block.
  - StallCnt is not affected.
  - ReadyE=1 the cycle after.
- StallCnt:
  - Increments by 1 on each edge where ValidM & !ReadyM & !flush.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - Cleared only by rst.
- Widths: all payload fields pass through unmodified; no arithmetic except StallCnt.

Test Plan:
- Reset: assert rst 2 cycles with ValidE=1, ALUResult=0xDEADBEEF -> all M outputs 0, ValidM=0, ReadyE=1, StallCnt=0.
- Streaming: ReadyM=1, send 3 instructions (ALUResult=0x10, 0x20, 0x30; RdE=1, 2, 3; RegWriteE=1) back-to-back -> each appears on ALUResultM/RdM one cycle after its accept edge, in order; ReadyE stays 1.
- Stall/skid:
  - Send A (0x100), then drop ReadyM while sending B (0x200) -> after B's edge, FULL, ReadyE=0, ALUResultM=0x100.
  - Hold ReadyM=0 for 4 cycles -> StallCnt=4 more, outputs stable.
  - Raise ReadyM -> 0x100 consumed, then 0x200 presented next cycle, ReadyE=1.
- Flush in FULL with ValidE=1, MemWriteE=1 -> next cycle ValidM=0, MemWriteM=0, RegWriteM=0, RdM=0; the flushed-cycle input never appears on the M outputs.
- Bubble squash: ValidE=0 with RegWriteE=1, MemWriteE=1, RdE=7 -> RegWriteM=0, MemWriteM=0, RdM=0.
- Saturation: CNT_W=4, hold ValidM=1, ReadyM=0 for 20 cycles -> StallCnt=15 and stays 15; rst returns it to 0.
